// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer: FSM states, datapath
// select codes and the decoded instruction class with its priority resolver.
package mc_ctrl_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd5;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_ALU   = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;
    localparam logic [1:0] WB_IMM  = 2'd3;

    localparam logic ALU_A_RS1 = 1'b0;
    localparam logic ALU_A_PC  = 1'b1;
    localparam logic ALU_B_RS2 = 1'b0;
    localparam logic ALU_B_IMM = 1'b1;

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_R,
        CLS_I,
        CLS_L,
        CLS_S,
        CLS_B,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC
    } instr_class_e;

    // Collapses the one-hot decoder flags; when several are set the first in this order wins.
    function automatic instr_class_e classify(
        input logic r, input logic i, input logic l, input logic s, input logic b,
        input logic jal, input logic jalr, input logic lui, input logic auipc
    );
        if (r)          return CLS_R;
        else if (i)     return CLS_I;
        else if (l)     return CLS_L;
        else if (s)     return CLS_S;
        else if (b)     return CLS_B;
        else if (jal)   return CLS_JAL;
        else if (jalr)  return CLS_JALR;
        else if (lui)   return CLS_LUI;
        else if (auipc) return CLS_AUIPC;
        return CLS_NONE;
    endfunction

endpackage

// File: rtl/mc_ctrl_perf_cnt.sv
// Free-running performance counter with an increment enable; wraps modulo 2^CNT_W.
module mc_ctrl_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            o_cnt <= '0;
        else if (i_en)
            o_cnt <= o_cnt + CNT_W'(1);
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with a terminal
// TRAP for undecodable instructions, plus cycle and retired-instruction counters.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_type,
    input  logic             l_type,
    input  logic             s_type,
    input  logic             r_type,
    input  logic             jal,
    input  logic             jalr,
    input  logic             lui,
    input  logic             auipc,
    input  logic             b_type,
    input  logic             br_taken,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             alu_a_sel,
    output logic             alu_b_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             retire,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    logic [2:0]   r_state;
    logic [2:0]   w_next;
    instr_class_e r_cls;
    instr_class_e w_dec_cls;

    assign w_dec_cls = classify(r_type, i_type, l_type, s_type, b_type,
                                jal, jalr, lui, auipc);

    // The class is latched in DECODE; IR is stable until the next FETCH so this matches the live flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_cls   <= CLS_NONE;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE)
                r_cls <= w_dec_cls;
        end
    end

    always_comb begin
        w_next    = r_state;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        alu_a_sel = ALU_A_RS1;
        alu_b_sel = ALU_B_RS2;
        rf_we     = 1'b0;
        wb_sel    = WB_ALU;
        retire    = 1'b0;
        illegal   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                // Reset holds the FSM in FETCH, so the fetch request is masked by rst itself.
                imem_req = !rst;
                if (imem_ready && !rst) begin
                    ir_we  = 1'b1;
                    w_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_next = (w_dec_cls == CLS_NONE) ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                if (r_cls == CLS_AUIPC || r_cls == CLS_JAL || r_cls == CLS_B)
                    alu_a_sel = ALU_A_PC;
                if (r_cls != CLS_R && r_cls != CLS_B)
                    alu_b_sel = ALU_B_IMM;
                if (r_cls == CLS_B) begin
                    pc_we  = 1'b1;
                    pc_sel = br_taken ? PC_IMM : PC_PLUS4;
                    retire = 1'b1;
                    w_next = ST_FETCH;
                end else if (r_cls == CLS_L || r_cls == CLS_S) begin
                    w_next = ST_MEM;
                end else begin
                    w_next = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (r_cls == CLS_S);
                if (dmem_ready) begin
                    if (r_cls == CLS_S) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                        w_next = ST_FETCH;
                    end else begin
                        w_next = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
                w_next = ST_FETCH;
                case (r_cls)
                    CLS_L:          wb_sel = WB_LOAD;
                    CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
                    CLS_LUI:        wb_sel = WB_IMM;
                    default:        wb_sel = WB_ALU;
                endcase
                case (r_cls)
                    CLS_JAL:  pc_sel = PC_IMM;
                    CLS_JALR: pc_sel = PC_ALU;
                    default:  pc_sel = PC_PLUS4;
                endcase
            end
            ST_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                w_next = ST_FETCH;
            end
        endcase
    end

    mc_ctrl_perf_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (1'b1),
        .o_cnt (cycle_cnt)
    );

    mc_ctrl_perf_cnt #(.CNT_W(CNT_W)) u_instret_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (retire),
        .o_cnt (instret_cnt)
    );

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control sequencer for the RV32I core. Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, driving the instruction-memory and data-memory request handshakes and the datapath enables and selects. It takes the per-class type flags produced by the instruction decoder, which decodes the instruction register combinationally. It also keeps cycle and retired-instruction counters.

## Interface
- CNT_W, 32, width of cycle_cnt and instret_cnt
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_type, l_type, s_type, r_type, jal, jalr, lui, auipc, b_type  in  1 each  decoder class flags for the current instruction register (IR)
- br_taken  in  1  branch compare result from the ALU, valid in EXEC
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch data valid this cycle
- dmem_req  out  1  data memory request
- dmem_we  out  1  data request is a store
- dmem_ready  in  1  data access completes this cycle
- ir_we  out  1  load IR from fetched word
- pc_we  out  1  update PC
- pc_sel  out  2  0 = PC+4, 1 = PC+imm, 2 = ALU result with bit 0 cleared
- alu_a_sel  out  1  0 = rs1, 1 = PC
- alu_b_sel  out  1  0 = rs2, 1 = imm
- rf_we  out  1  register-file write enable
- wb_sel  out  2  0 = ALU, 1 = load data, 2 = PC+4, 3 = imm (LUI)
- retire  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  sticky: no class flag was set in DECODE
- cycle_cnt  out  CNT_W  cycles since reset
- instret_cnt  out  CNT_W  retired instructions since reset

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- **FETCH**
  - imem_req = 1; hold until imem_ready.
  - On ready: ir_we = 1 for that cycle (Mealy), then go to DECODE.
- **DECODE**
  - Single cycle; register read.
  - If no class flag is set, go to TRAP; otherwise go to EXEC.
  - Flags are checked in priority order r, i, l, s, b, jal, jalr, lui, auipc.
- **EXEC: operand selects**
  - alu_a_sel = 1 for auipc, jal and b; else 0.
  - alu_b_sel = 0 for r and b; else 1.
- **EXEC: branch**
  - pc_we = 1; pc_sel = 1 if br_taken, else 0.
  - retire = 1; go to FETCH.
- **EXEC: other classes**
  - l or s: go to MEM.
  - All others: go to WB.
- **MEM**
  - dmem_req = 1 and dmem_we = s_type; both held until dmem_ready.
  - Store on ready: pc_we = 1, pc_sel = 0, retire = 1, go to FETCH.
  - Load on ready: go to WB.
- **WB**
  - rf_we = 1 for one cycle.
  - wb_sel: 1 for l, 2 for jal/jalr, 3 for lui, else 0.
  - pc_we = 1; pc_sel: 1 for jal, 2 for jalr, else 0.
  - retire = 1; go to FETCH.
- **TRAP**
  - illegal = 1; all request and enable outputs are 0.
  - Terminal until rst.
- **Counters**
  - cycle_cnt increments every cycle out of reset, including in TRAP.
  - instret_cnt increments on retire.
  - Both wrap modulo 2^CNT_W.

## Timing
- While rst is high: state = FETCH; every output is 0, including imem_req; counters are 0; illegal = 0.
- First cycle after rst deasserts: imem_req = 1.
- Latency with zero-wait memories (ready in the same cycle as req):
  - branch: 3 cycles
  - r, i, lui, auipc, jal, jalr: 4 cycles
  - store: 4 cycles
  - load: 5 cycles
- Each memory wait cycle adds 1 to the latency.
- A req, once raised, stays high until its ready is seen. A ready seen while its req is low is ignored.
- rst during an outstanding request drops req asynchronously. The memory must tolerate an abandoned request.
- Class flags are sampled only in DECODE, EXEC and WB. IR is stable outside FETCH.
- Only one class flag is set for legal encodings. If several are set, the priority order in Operation applies.

## Structure
- Add to the shared defines file:
  - state encodings (3-bit)
  - pc_sel, wb_sel and alu select codes
- One sub-module, perf_cnt: a CNT_W counter with increment enable, instantiated twice (cycle, instret).
- The FSM and output decode stay in mc_ctrl.

## Test plan
- add (r_type), zero-wait memories:
  - Sequence FETCH→DECODE→EXEC→WB.
  - rf_we, pc_we (pc_sel = 0) and retire all high in cycle 4.
  - instret_cnt goes 0→1; cycle_cnt = 4.
- beq with br_taken = 1, then with br_taken = 0:
  - pc_sel = 1, then 0, each in the EXEC cycle.
  - No rf_we in either case; 3 cycles each.
- lw with dmem_ready delayed 2 cycles:
  - dmem_req held 3 cycles with dmem_we = 0.
  - WB has wb_sel = 1; total 7 cycles.
- sw:
  - dmem_we = 1 throughout MEM.
  - Retire in the MEM ready cycle; no rf_we.
- jalr, then lui:
  - jalr: wb_sel = 2, pc_sel = 2.
  - lui: wb_sel = 3, pc_sel = 0.
- All class flags 0 in DECODE:
  - Enters TRAP; illegal = 1; imem_req stays 0 for 20 cycles; cycle_cnt keeps counting.
- rst asserted mid-MEM: outputs clear immediately; after release, imem_req = 1 and illegal = 0.
